dmem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: port 0 is the core's memory stage and port 1 is the program/data loader used to preload memory and dump results. The arbiter grants at most one access per cycle using round-robin arbitration. It routes synchronous read data back to the requester that issued the read. Port 0 can hold an atomic lock so that a read followed by a write (swap-style sequences) is never interleaved with loader traffic.

---
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one synchronous data-memory port between two requesters:
//   port 0 : core memory stage (may hold an atomic lock)
//   port 1 : program/data loader (preload and result dump)
//
// Round-robin arbitration issues at most one memory access per cycle. Grants
// are combinational, so a winning port is issued in the same cycle it asks.
// Read data comes back one cycle later and is steered to whichever port
// issued the read. When port 0 holds the lock, port 1 is shut out until
// port 0 makes an unlocked access, so a read-modify-write sequence from the
// core cannot be split by loader traffic.
//
// Ports
//   clk_i                 rising-edge clock
//   rst_i                 synchronous reset, active low
//   m0_req_i / m1_req_i   request, command fields held stable until granted
//   m0_we_i / m1_we_i     1 = write, 0 = read
//   m0_lock_i             port 0 lock request, sampled with a port 0 grant
//   m0_addr_i / m1_addr_i byte address
//   m0_wdata_i/m1_wdata_i write data
//   m0_gnt_o / m1_gnt_o   combinational grant (access issued this cycle)
//   m0_rvalid_o/m1_rvalid_o read data valid, one cycle after a granted read
//   m0_rdata_o / m1_rdata_o read data, zero when the matching rvalid is low
//   mem_en_o              memory access strobe
//   mem_we_o              memory write enable
//   mem_addr_o            memory byte address
//   mem_wdata_o           memory write data
//   mem_rdata_i           memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Identifies one of the two requesters.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Arbitration and read-return state.
    port_e last_q, last_d;
    logic  lock_q, lock_d;
    logic  rtag_valid_q, rtag_valid_d;
    port_e rtag_owner_q, rtag_owner_d;

    logic  grant0;
    logic  grant1;

    // Grant selection. While reset is held nothing is granted. A held lock
    // reserves the port for requester 0 even when it is idle. Otherwise a
    // lone requester wins, and a tie goes to the port that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_i) begin
            if (lock_q) begin
                grant0 = m0_req_i;
            end else if (m0_req_i && m1_req_i) begin
                grant0 = (last_q == PORT1);
                grant1 = (last_q == PORT0);
            end else begin
                grant0 = m0_req_i;
                grant1 = m1_req_i;
            end
        end
    end

    assign m0_gnt_o = grant0;
    assign m1_gnt_o = grant1;

    // Memory command mux: forward the granted port's command, drive zeros
    // when the port is idle so the memory bus is quiet between accesses.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant0) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (grant1) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    // Next-state logic. The round-robin pointer and the lock only move on a
    // real grant, so a requester that drops its request early cannot disturb
    // them. The read tag is rewritten every cycle, which is what lets reads
    // be issued back to back: each tag lives for exactly one cycle.
    always_comb begin
        last_d       = last_q;
        lock_d       = lock_q;
        rtag_valid_d = 1'b0;
        rtag_owner_d = rtag_owner_q;

        if (grant0) begin
            last_d       = PORT0;
            lock_d       = m0_lock_i;
            rtag_valid_d = ~m0_we_i;
            rtag_owner_d = PORT0;
        end else if (grant1) begin
            last_d       = PORT1;
            rtag_valid_d = ~m1_we_i;
            rtag_owner_d = PORT1;
        end
    end

    // State registers. Reset leaves the pointer at port 1 so the first tie
    // goes to the core, drops any lock and discards an in-flight read tag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_q       <= PORT1;
            lock_q       <= 1'b0;
            rtag_valid_q <= 1'b0;
            rtag_owner_q <= PORT0;
        end else begin
            last_q       <= last_d;
            lock_q       <= lock_d;
            rtag_valid_q <= rtag_valid_d;
            rtag_owner_q <= rtag_owner_d;
        end
    end

    // Read return steering. Valid is also gated by reset so a read granted
    // just before reset asserts never shows up at the requester.
    always_comb begin
        m0_rvalid_o = rst_i && rtag_valid_q && (rtag_owner_q == PORT0);
        m1_rvalid_o = rst_i && rtag_valid_q && (rtag_owner_q == PORT1);
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A small synchronous memory model sits on
// the memory port. Stimulus drives one cycle at a time, checks grants and
// the memory command in that cycle, and pushes the expected read return into
// a scoreboard queue. A monitor pops the queue whenever a port shows rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rdExp_t;

    logic        clk;
    logic        rstN;
    logic        m0Req, m0We, m0Lock;
    logic [31:0] m0Addr, m0Wdata;
    logic        m1Req, m1We;
    logic [31:0] m1Addr, m1Wdata;
    logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
    logic [31:0] m0Rdata, m1Rdata;
    logic        memEn, memWe;
    logic [31:0] memAddr, memWdata, memRdata;

    logic [31:0] memArray [0:63];
    rdExp_t      expQ [$];
    int          checks = 0;
    int          failures = 0;
    int          gnt0Seen = 0;
    int          gnt1Seen = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rstN),
        .m0_req_i    (m0Req),
        .m0_we_i     (m0We),
        .m0_lock_i   (m0Lock),
        .m0_addr_i   (m0Addr),
        .m0_wdata_i  (m0Wdata),
        .m0_gnt_o    (m0Gnt),
        .m0_rvalid_o (m0Rvalid),
        .m0_rdata_o  (m0Rdata),
        .m1_req_i    (m1Req),
        .m1_we_i     (m1We),
        .m1_addr_i   (m1Addr),
        .m1_wdata_i  (m1Wdata),
        .m1_gnt_o    (m1Gnt),
        .m1_rvalid_o (m1Rvalid),
        .m1_rdata_o  (m1Rdata),
        .mem_en_o    (memEn),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model preloaded with word i = i; reads return one cycle later.
    initial begin
        for (int i = 0; i < 64; i++) memArray[i] = i;
        memRdata = '0;
    end

    always @(posedge clk) begin
        if (memEn && memWe) memArray[memAddr[7:2]] <= memWdata;
        if (memEn && !memWe) memRdata <= memArray[memAddr[7:2]];
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of commands, checks grant and memory command at the
    // falling edge, queues the expected read return, then steps to just
    // after the next rising edge.
    task automatic applyStimulus(
        input logic r0, input logic w0, input logic l0,
        input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1,
        input logic [31:0] a1, input logic [31:0] d1,
        input logic expG0, input logic expG1,
        input logic expRet, input logic [31:0] expData);
        rdExp_t e;
        m0Req = r0; m0We = w0; m0Lock = l0; m0Addr = a0; m0Wdata = d0;
        m1Req = r1; m1We = w1; m1Addr = a1; m1Wdata = d1;
        @(negedge clk);
        checkOutput("m0Gnt", {31'd0, m0Gnt}, {31'd0, expG0});
        checkOutput("m1Gnt", {31'd0, m1Gnt}, {31'd0, expG1});
        gnt0Seen += int'(m0Gnt);
        gnt1Seen += int'(m1Gnt);
        if (expG0) begin
            checkOutput("memAddr0", memAddr, a0);
            checkOutput("memWe0", {31'd0, memWe}, {31'd0, w0});
            if (w0) checkOutput("memWdata0", memWdata, d0);
        end else if (expG1) begin
            checkOutput("memAddr1", memAddr, a1);
            checkOutput("memWe1", {31'd0, memWe}, {31'd0, w1});
            if (w1) checkOutput("memWdata1", memWdata, d1);
        end else begin
            checkOutput("memIdle", {memEn, memWe, memAddr[29:0]}, 32'd0);
        end
        if (expRet) begin
            e.port = expG1;
            e.data = expData;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every falling edge, match any read return against the
    // scoreboard and confirm the non-returning port shows zero data.
    always @(negedge clk) begin
        rdExp_t e;
        if (m0Rvalid && m1Rvalid) begin
            checks++;
            failures++;
            $display("[TB] FAIL bothRvalid: got both rvalid high, expected at most one at %0t", $time);
        end else if (m0Rvalid || m1Rvalid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedRvalid: got rvalid m0=%0b m1=%0b, expected none at %0t",
                         m0Rvalid, m1Rvalid, $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("rvalidPort", {31'd0, m1Rvalid}, {31'd0, e.port});
                checkOutput("rdata", m1Rvalid ? m1Rdata : m0Rdata, e.data);
            end
        end
        if (!m0Rvalid) checkOutput("m0RdataIdle", m0Rdata, 32'd0);
        if (!m1Rvalid) checkOutput("m1RdataIdle", m1Rdata, 32'd0);
    end

    // Directed test sequence.
    initial begin
        int n0;
        int n1;
        logic g0;
        rstN = 1'b0;
        m0Req = 0; m0We = 0; m0Lock = 0; m0Addr = 0; m0Wdata = 0;
        m1Req = 0; m1We = 0; m1Addr = 0; m1Wdata = 0;
        @(posedge clk);
        #1;

        // Reset: no grants while held, even with both ports requesting.
        applyStimulus(1, 0, 0, 32'h10, 0, 1, 1, 32'h40, 32'h1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h10, 0, 1, 1, 32'h40, 32'h1, 0, 0, 0, 0);
        rstN = 1'b1;

        // Single read of word 4.
        applyStimulus(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Re-reset so the pointer starts at port 1, then six contended
        // cycles: grants must alternate starting with port 0.
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        gnt0Seen = 0;
        gnt1Seen = 0;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            g0 = (i % 2 == 0);
            applyStimulus(1, 0, 0, n0 * 4, 0, 1, 1, 32'h40, 32'hA000_0000 + n1,
                          g0, !g0, g0, n0);
            if (g0) n0++;
            else n1++;
        end
        m0Req = 0; m1Req = 0;
        checkOutput("gnt0Count", gnt0Seen, 3);
        checkOutput("gnt1Count", gnt1Seen, 3);
        checkOutput("word16", memArray[16], 32'hA000_0002);

        // Lock: m0 locked read, m0 idle (m1 still blocked), m0 unlocked
        // write, then m1 finally wins.
        applyStimulus(1, 0, 1, 32'h8, 0, 1, 1, 32'h44, 32'h1234, 1, 0, 1, 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h44, 32'h1234, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h8, 32'd2, 1, 1, 32'h44, 32'h1234, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h44, 32'h1234, 0, 1, 0, 0);
        checkOutput("word17", memArray[17], 32'h1234);

        // Back-to-back reads alternating owners.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, 1, 32'd1);
        applyStimulus(1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 1, 0, 1, 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, 1, 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after a granted read: its return must vanish, and a
        // tie afterwards goes to port 0.
        applyStimulus(1, 0, 1, 32'hC, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        applyStimulus(1, 0, 0, 32'h4, 0, 1, 0, 32'h8, 0, 1, 0, 1, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, 1, 32'd2);

        // Reset drops a held lock: m1 alone must be granted afterwards.
        applyStimulus(1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, 0, 1, 1, 32'd1);

        // Write then read of the same address from different ports.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        checkOutput("pendingReturns", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
